// File: rtl/hazard_scheduler.sv
// hazard_scheduler
//   Stall/forward decision logic for the D stage of a 5-stage MIPS pipeline.
//   A registered scoreboard tracks {dst, tnew} for the instructions in E, M
//   and W; the D-stage operand demand (Tuse) is compared against it to decide
//   a stall or the D-stage forwarding source. A busy countdown sequences the
//   multi-cycle mult/div unit.
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   d_rs, d_rt               source register fields of the D instruction
//   d_tuse_rs, d_tuse_rt     cycles until the operand is consumed (3 = unused)
//   d_dst, d_tnew            destination (0 = none) and result latency from E
//   d_md_start, d_md_div     D is mult/div; d_md_div selects DIV_LAT
//   d_md_use                 D is mfhi/mflo/mthi/mtlo
//   stall                    freeze PC + D reg, bubble into E
//   fwd_rs_sel, fwd_rt_sel   0 GRF, 1 E, 2 M, 3 W
//   md_busy                  mult/div countdown non-zero
module hazard_scheduler #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);

  logic [4:0]    e_dst_q, e_dst_d, m_dst_q, m_dst_d, w_dst_q, w_dst_d;
  logic [1:0]    e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       stall_rs, stall_rt, stall_md;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Returns {stall, sel}. Only the newest matching slot counts: an older
  // in-flight write to the same register is shadowed by the younger one.
  function automatic logic [2:0] resolve(
    input logic [4:0] r,    input logic [1:0] tuse,
    input logic [4:0] e_d,  input logic [1:0] e_t,
    input logic [4:0] m_d,  input logic [1:0] m_t,
    input logic [4:0] w_d,  input logic [1:0] w_t
  );
    logic [1:0] t;
    logic [1:0] src;
    logic       hit;
    hit = 1'b1;
    t   = 2'd0;
    src = 2'd0;
    if (r == 5'd0 || tuse == 2'd3) hit = 1'b0;
    else if (r == e_d)             begin t = e_t; src = 2'd1; end
    else if (r == m_d)             begin t = m_t; src = 2'd2; end
    else if (r == w_d)             begin t = w_t; src = 2'd3; end
    else                           hit = 1'b0;
    if (!hit)            return 3'b000;
    else if (t != 2'd0)  return {(t > tuse), 2'd0};
    else                 return {1'b0, src};
  endfunction

  always_comb begin
    {stall_rs, fwd_rs_sel} = resolve(d_rs, d_tuse_rs, e_dst_q, e_tnew_q,
                                     m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
    {stall_rt, fwd_rt_sel} = resolve(d_rt, d_tuse_rt, e_dst_q, e_tnew_q,
                                     m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
    md_busy  = (cnt_q != '0);
    stall_md = (d_md_start | d_md_use) & md_busy;
    stall    = stall_rs | stall_rt | stall_md;
  end

  always_comb begin
    // A stall turns the E entry into a bubble; M and W keep draining.
    e_dst_d  = stall ? 5'd0 : d_dst;
    e_tnew_d = stall ? 2'd0 : d_tnew;
    m_dst_d  = e_dst_q;
    m_tnew_d = sat_dec(e_tnew_q);
    w_dst_d  = m_dst_q;
    w_tnew_d = sat_dec(m_tnew_q);
    cnt_d    = cnt_q;
    if (!stall && d_md_start) cnt_d = d_md_div ? DIV_CNT : MULT_CNT;
    else if (md_busy)         cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_dst_q  <= '0;
      e_tnew_q <= '0;
      m_dst_q  <= '0;
      m_tnew_q <= '0;
      w_dst_q  <= '0;
      w_tnew_q <= '0;
      cnt_q    <= '0;
    end else begin
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
      w_tnew_q <= w_tnew_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed-vector bench for hazard_scheduler. The driver applies one D-stage
// instruction per cycle and queues the hand-computed response; a monitor pops
// one entry per cycle on the falling edge and compares.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  hazard_scheduler #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst(rst),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;  logic [1:0] tu_rs;
    logic [4:0] rt;  logic [1:0] tu_rt;
    logic [4:0] dst; logic [1:0] tnew;
    logic       ms;  logic       mdiv; logic mu;
  } instr_t;

  typedef struct {
    string      name;
    logic [5:0] exp;   // {stall, fwd_rs_sel, fwd_rt_sel, md_busy}
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic instr_t mk(input logic [4:0] rs, input logic [1:0] tu_rs,
                                input logic [4:0] rt, input logic [1:0] tu_rt,
                                input logic [4:0] dst, input logic [1:0] tnew,
                                input logic ms, input logic mdiv, input logic mu);
    instr_t i;
    i.rs = rs; i.tu_rs = tu_rs; i.rt = rt; i.tu_rt = tu_rt;
    i.dst = dst; i.tnew = tnew; i.ms = ms; i.mdiv = mdiv; i.mu = mu;
    return i;
  endfunction

  function automatic instr_t nop();
    return mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic step(input string name, input logic rstv, input instr_t i,
                      input logic e_st, input logic [1:0] e_rs,
                      input logic [1:0] e_rt, input logic e_busy);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rstv;
    d_rs = i.rs; d_tuse_rs = i.tu_rs; d_rt = i.rt; d_tuse_rt = i.tu_rt;
    d_dst = i.dst; d_tnew = i.tnew;
    d_md_start = i.ms; d_md_div = i.mdiv; d_md_use = i.mu;
    e.name = name;
    e.exp  = {e_st, e_rs, e_rt, e_busy};
    q.push_back(e);
  endtask

  task automatic flush(input int n);
    for (int k = 0; k < n; k++) step("flush", 1'b0, nop(), 1'b0, 2'd0, 2'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e   = q.pop_front();
      act = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got stall=%b rs=%0d rt=%0d busy=%b, want stall=%b rs=%0d rt=%0d busy=%b",
                 e.name, act[5], act[4:3], act[2:1], act[0],
                 e.exp[5], e.exp[4:3], e.exp[2:1], e.exp[0]);
      end
    end
  end

  instr_t beq1, addu5, beq5, mflo, mfhi4;

  initial begin
    d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_dst = 0; d_tnew = 0;
    d_md_start = 0; d_md_div = 0; d_md_use = 0;

    // Reset state, with a demanding instruction presented in D.
    step("reset0", 1'b1, mk(5'd1, 2'd0, 5'd2, 2'd0, 5'd1, 2'd2, 1'b1, 1'b0, 1'b1),
         1'b0, 2'd0, 2'd0, 1'b0);
    step("reset1", 1'b1, nop(), 1'b0, 2'd0, 2'd0, 1'b0);
    flush(1);

    // lw $1 then beq $1: two stall cycles then forward from W.
    beq1 = mk(5'd1, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("lw1",      1'b0, mk(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b0);
    step("beq_st1",  1'b0, beq1, 1'b1, 2'd0, 2'd0, 1'b0);
    step("beq_st2",  1'b0, beq1, 1'b1, 2'd0, 2'd0, 1'b0);
    step("beq_fwdW", 1'b0, beq1, 1'b0, 2'd3, 2'd0, 1'b0);
    flush(3);

    // addu $3 then sw rt=$3: no stall, GRF; a later reader sees M.
    step("addu3", 1'b0, mk(5'd0, 2'd1, 5'd0, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b0);
    step("sw3",   1'b0, mk(5'd0, 2'd1, 5'd3, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b0);
    step("sw3_fwdM", 1'b0, mk(5'd0, 2'd1, 5'd3, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0),
         1'b0, 2'd0, 2'd2, 1'b0);
    flush(3);

    // jal then jr $31: forward from E.
    step("jal", 1'b0, mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b0);
    step("jr31", 1'b0, mk(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0),
         1'b0, 2'd1, 2'd0, 1'b0);
    flush(3);

    // lw $0 then beq $0: register 0 never stalls or forwards.
    step("lw0", 1'b0, mk(5'd0, 2'd1, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b0);
    step("beq0", 1'b0, mk(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b0);
    flush(3);

    // Two writes to $5: the newest (E, tnew=1) shadows M and forces a stall.
    addu5 = mk(5'd0, 2'd1, 5'd0, 2'd1, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
    beq5  = mk(5'd5, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("addu5a", 1'b0, addu5, 1'b0, 2'd0, 2'd0, 1'b0);
    step("addu5b", 1'b0, addu5, 1'b0, 2'd0, 2'd0, 1'b0);
    step("beq5_newestE", 1'b0, beq5, 1'b1, 2'd0, 2'd0, 1'b0);
    step("beq5_fwdM",    1'b0, beq5, 1'b0, 2'd2, 2'd0, 1'b0);
    flush(3);

    // mult then mflo: five stall cycles, issue on the sixth.
    mflo = mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
    step("mult", 1'b0, mk(5'd0, 2'd1, 5'd0, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) step("mflo_stall", 1'b0, mflo, 1'b1, 2'd0, 2'd0, 1'b1);
    step("mflo_issue", 1'b0, mflo, 1'b0, 2'd0, 2'd0, 1'b0);
    flush(2);

    // div then mult: ten stall cycles, then mult loads MULT_LAT.
    step("div", 1'b0, mk(5'd0, 2'd1, 5'd0, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b0);
    for (int k = 0; k < 10; k++)
      step("mult_stall", 1'b0, mk(5'd0, 2'd1, 5'd0, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0),
           1'b1, 2'd0, 2'd0, 1'b1);
    step("mult_issue", 1'b0, mk(5'd0, 2'd1, 5'd0, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) step("mult_busy", 1'b0, nop(), 1'b0, 2'd0, 2'd0, 1'b1);
    step("mult_done", 1'b0, nop(), 1'b0, 2'd0, 2'd0, 1'b0);
    flush(2);

    // div, three cycles of countdown (cnt reaches 7), lw $4, then reset
    // while a hazard on $4 and the md unit are both pending.
    mfhi4 = mk(5'd4, 2'd0, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b1);
    step("div2", 1'b0, mk(5'd0, 2'd1, 5'd0, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b0);
    step("div2_b10", 1'b0, nop(), 1'b0, 2'd0, 2'd0, 1'b1);
    step("div2_b9",  1'b0, nop(), 1'b0, 2'd0, 2'd0, 1'b1);
    step("lw4_b8",   1'b0, mk(5'd0, 2'd1, 5'd0, 2'd3, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0),
         1'b0, 2'd0, 2'd0, 1'b1);
    step("pre_reset",   1'b0, mfhi4, 1'b1, 2'd0, 2'd0, 1'b1);
    step("async_reset", 1'b1, mfhi4, 1'b0, 2'd0, 2'd0, 1'b0);
    step("post_reset",  1'b0, mfhi4, 1'b0, 2'd0, 2'd0, 1'b0);
    flush(2);

    // Let the monitor drain, with a bounded wait.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
